// File: rtl/apb_pkg.sv
// Shared types and helpers for the wait-state APB memory slave.
package apb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  // Word-index width; a single-word memory still needs a 1-bit index.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/apb_mem_array.sv
// Byte-lane memory: synchronous byte-enabled write, asynchronous read, async clear.
module apb_mem_array #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int IDX_W      = 6
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    we,
  input  logic [IDX_W-1:0]        waddr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic [IDX_W-1:0]        raddr,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int STRB_W = DATA_WIDTH / 8;

  genvar gi;
  generate
    for (gi = 0; gi < STRB_W; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];

      always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
          for (int w = 0; w < DEPTH; w++) lane_mem[w] <= '0;
        end else if (we && wstrb[gi]) begin
          lane_mem[waddr] <= wdata[gi*8 +: 8];
        end
      end

      // Guard keeps non-power-of-two depths from reading past the array.
      assign rdata[gi*8 +: 8] = (32'(raddr) < 32'(DEPTH)) ? lane_mem[raddr] : 8'h00;
    end
  endgenerate

endmodule

// File: rtl/apb_mem_slave_ws.sv
// APB4 memory slave with byte strobes, programmable wait states, PSLVERR on
// out-of-range words and a sticky protocol-error flag.
module apb_mem_slave_ws
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int WS_WIDTH   = 4
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  input  logic [WS_WIDTH-1:0]     ws_cfg,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR,
  output logic                    proto_err
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFFS_W = $clog2(STRB_W);
  localparam int IDX_W  = idx_width(DEPTH);

  state_t                  state_reg, state_next;
  logic [WS_WIDTH-1:0]     cnt_reg, cnt_next;
  logic                    err_reg, err_next;
  logic                    write_reg, write_next;
  logic                    proto_err_reg, proto_err_next;
  logic [IDX_W-1:0]        idx_reg, idx_next;
  logic [DATA_WIDTH-1:0]   wdata_reg, wdata_next;
  logic [DATA_WIDTH-1:0]   prdata_reg, prdata_next;
  logic [STRB_W-1:0]       strb_reg, strb_next;

  logic [ADDR_WIDTH-1:0]   word_addr;
  logic [IDX_W-1:0]        addr_idx;
  logic                    addr_err;
  logic [DATA_WIDTH-1:0]   mem_rdata;
  logic                    mem_we;

  // Full shifted address is kept so the range check sees every upper bit.
  assign word_addr = PADDR >> OFFS_W;
  assign addr_idx  = word_addr[IDX_W-1:0];
  assign addr_err  = 32'(word_addr) >= 32'(DEPTH);

  assign PREADY    = (state_reg == ACCESS) && PSEL && PENABLE && (cnt_reg == '0);
  assign PSLVERR   = PREADY && err_reg;
  assign mem_we    = PREADY && write_reg && !err_reg;
  assign PRDATA    = prdata_reg;
  assign proto_err = proto_err_reg;

  apb_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_W      (IDX_W)
  ) u_mem (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .we     (mem_we),
    .waddr  (idx_reg),
    .wdata  (wdata_reg),
    .wstrb  (strb_reg),
    .raddr  (addr_idx),
    .rdata  (mem_rdata)
  );

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    err_next       = err_reg;
    write_next     = write_reg;
    proto_err_next = proto_err_reg;
    idx_next       = idx_reg;
    wdata_next     = wdata_reg;
    prdata_next    = prdata_reg;
    strb_next      = strb_reg;
    case (state_reg)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          state_next = ACCESS;
          cnt_next   = ws_cfg;
          err_next   = addr_err;
          idx_next   = addr_idx;
          write_next = PWRITE;
          wdata_next = PWDATA;
          strb_next  = PSTRB;
          // Writes leave PRDATA holding the last read value.
          if (!PWRITE) prdata_next = addr_err ? '0 : mem_rdata;
        end else if (PSEL && PENABLE) begin
          proto_err_next = 1'b1;
        end
      end
      ACCESS: begin
        if (!(PSEL && PENABLE)) begin
          proto_err_next = 1'b1;
          state_next     = IDLE;
        end else if (cnt_reg != '0) begin
          cnt_next = cnt_reg - WS_WIDTH'(1);
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      err_reg       <= 1'b0;
      write_reg     <= 1'b0;
      proto_err_reg <= 1'b0;
      idx_reg       <= '0;
      wdata_reg     <= '0;
      prdata_reg    <= '0;
      strb_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      err_reg       <= err_next;
      write_reg     <= write_next;
      proto_err_reg <= proto_err_next;
      idx_reg       <= idx_next;
      wdata_reg     <= wdata_next;
      prdata_reg    <= prdata_next;
      strb_reg      <= strb_next;
    end
  end

endmodule

// File: tb/tb_apb_mem_slave_ws.sv
// Self-checking bench: directed scenarios plus randomized transfers against a
// word-array reference model of the slave.
module tb_apb_mem_slave_ws;

  localparam int AW    = 12;
  localparam int DW    = 32;
  localparam int DEPTH = 64;
  localparam int WSW   = 4;

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic          PSEL, PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [3:0]    PSTRB;
  logic [WSW-1:0] ws_cfg;
  logic [DW-1:0] PRDATA;
  logic          PREADY, PSLVERR, proto_err;

  int            n_checks = 0;
  int            n_errors = 0;
  int            n_txn    = 0;
  logic [31:0]   ref_mem [DEPTH];
  bit            ref_proto;
  logic [31:0]   rd;

  apb_mem_slave_ws #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .WS_WIDTH   (WSW)
  ) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PSTRB     (PSTRB),
    .ws_cfg    (ws_cfg),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR),
    .proto_err (proto_err)
  );

  always #5 PCLK = ~PCLK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
    ref_proto = 1'b0;
  endtask

  task automatic do_reset();
    PRESET  = 1'b1;
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    clear_model();
    @(negedge PCLK);
    @(negedge PCLK);
    PRESET = 1'b0;
  endtask

  task automatic go_idle();
    @(posedge PCLK); #1;
    PSEL    = 1'b0;
    PENABLE = 1'b0;
  endtask

  // One complete transfer; starts setup on the next rising edge so calls chain back-to-back.
  task automatic apb_xfer(input bit wr, input logic [AW-1:0] addr, input logic [31:0] wd,
                          input logic [3:0] strb, input int ws, output logic [31:0] rdata);
    int          idx;
    bit          err;
    logic [31:0] exp_rd;
    int          waits;
    bit          done;
    idx    = int'(addr >> 2);
    err    = (idx >= DEPTH);
    exp_rd = err ? 32'h0 : ref_mem[idx];
    waits  = 0;
    done   = 1'b0;
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr;
    PWDATA = wd; PSTRB = strb; ws_cfg = WSW'(ws);
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    ws_cfg  = WSW'($urandom);
    while (!done) begin
      @(negedge PCLK);
      if (PREADY) begin
        done = 1'b1;
      end else begin
        waits++;
        ws_cfg = WSW'($urandom);
        if (waits > 40) begin
          check_val("ready_timeout", 32'(waits), 32'(ws));
          done = 1'b1;
        end
      end
    end
    rdata = PRDATA;
    check_val("wait_states", 32'(waits), 32'(ws));
    check_val("pslverr", 32'(PSLVERR), 32'(err));
    if (!wr) check_val("prdata", PRDATA, exp_rd);
    if (wr && !err)
      for (int b = 0; b < 4; b++)
        if (strb[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
    n_txn++;
    $display("txn %0d: %s addr=0x%03h wdata=0x%08h strb=%h ws=%0d waits=%0d slverr=%0d prdata=0x%08h",
             n_txn, wr ? "WR" : "RD", addr, wd, strb, ws, waits, PSLVERR, rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; PSTRB = '0; ws_cfg = '0;
    clear_model();
    #12;
    check_val("rst_pready", 32'(PREADY), 32'h0);
    check_val("rst_pslverr", 32'(PSLVERR), 32'h0);
    check_val("rst_prdata", PRDATA, 32'h0);
    check_val("rst_proto", 32'(proto_err), 32'h0);
    @(negedge PCLK);
    PRESET = 1'b0;

    // Zero wait states, write then immediate read.
    apb_xfer(1'b1, 12'h004, 32'hDEADBEEF, 4'hF, 0, rd);
    apb_xfer(1'b0, 12'h004, 32'h0, 4'hF, 0, rd);
    check_val("t1_readback", rd, 32'hDEADBEEF);
    go_idle();

    // Three wait states with ws_cfg scrambled during the access phase.
    apb_xfer(1'b0, 12'h004, 32'h0, 4'h0, 3, rd);
    check_val("t2_readback", rd, 32'hDEADBEEF);

    // Byte strobes merge; empty strobe leaves the word alone.
    apb_xfer(1'b1, 12'h008, 32'h11223344, 4'hF, 1, rd);
    apb_xfer(1'b1, 12'h008, 32'hAABBCCDD, 4'h5, 2, rd);
    apb_xfer(1'b0, 12'h008, 32'h0, 4'h0, 0, rd);
    check_val("t3_merge", rd, 32'h11BB33DD);
    apb_xfer(1'b1, 12'h008, 32'hFFFFFFFF, 4'h0, 0, rd);
    apb_xfer(1'b0, 12'h008, 32'h0, 4'h0, 0, rd);
    check_val("t3_strb0", rd, 32'h11BB33DD);

    // Index 64 errors, index 63 is the last good word.
    apb_xfer(1'b1, 12'h100, 32'h12345678, 4'hF, 1, rd);
    apb_xfer(1'b0, 12'h100, 32'h0, 4'h0, 0, rd);
    check_val("t4_err_rdata", rd, 32'h0);
    apb_xfer(1'b1, 12'h0FC, 32'hCAFEF00D, 4'hF, 0, rd);
    apb_xfer(1'b0, 12'h0FC, 32'h0, 4'h0, 2, rd);
    check_val("t4_last_word", rd, 32'hCAFEF00D);
    go_idle();

    // PSEL&PENABLE with no setup phase.
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 12'h004;
    PWDATA = 32'h0; PSTRB = 4'hF;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge PCLK);
    check_val("t5_proto_nosetup", 32'(proto_err), 32'h1);
    ref_proto = 1'b1;
    apb_xfer(1'b0, 12'h004, 32'h0, 4'h0, 0, rd);
    go_idle();

    do_reset();
    check_val("t5_proto_cleared", 32'(proto_err), 32'h0);

    // PENABLE dropped during a wait state aborts the write.
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 12'h010;
    PWDATA = 32'h55AA55AA; PSTRB = 4'hF; ws_cfg = 4'd3;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    check_val("t5_wait_pready", 32'(PREADY), 32'h0);
    @(posedge PCLK); #1;
    PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PSEL = 1'b0;
    @(negedge PCLK);
    check_val("t5_proto_abort", 32'(proto_err), 32'h1);
    ref_proto = 1'b1;
    apb_xfer(1'b0, 12'h010, 32'h0, 4'h0, 1, rd);
    check_val("t5_no_write", rd, 32'h0);
    go_idle();
    @(negedge PCLK);
    check_val("t5_proto_sticky", 32'(proto_err), 32'h1);

    // Reset lands on the completing cycle of a write.
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 12'h00C;
    PWDATA = 32'hA5A5A5A5; PSTRB = 4'hF; ws_cfg = 4'd1;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    check_val("t6_wait_pready", 32'(PREADY), 32'h0);
    @(negedge PCLK);
    check_val("t6_ready_before_rst", 32'(PREADY), 32'h1);
    #1 PRESET = 1'b1;
    #1;
    check_val("t6_pready_drop", 32'(PREADY), 32'h0);
    check_val("t6_proto", 32'(proto_err), 32'h0);
    clear_model();
    PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge PCLK);
    PRESET = 1'b0;
    apb_xfer(1'b0, 12'h00C, 32'h0, 4'h0, 0, rd);
    check_val("t6_word_zero", rd, 32'h0);
    apb_xfer(1'b1, 12'h00C, 32'h0BADC0DE, 4'hF, 2, rd);
    apb_xfer(1'b0, 12'h00C, 32'h0, 4'h0, 1, rd);
    check_val("t6_after_rst", rd, 32'h0BADC0DE);

    // Randomized traffic, unaligned addresses and occasional gaps.
    for (int n = 0; n < 80; n++) begin
      apb_xfer(1'($urandom), AW'($urandom_range(0, 12'h13F)), $urandom,
               4'($urandom), int'($urandom_range(0, 4)), rd);
      if ($urandom_range(0, 2) == 0) go_idle();
    end
    go_idle();
    @(negedge PCLK);
    check_val("final_proto", 32'(proto_err), 32'(ref_proto));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
